// File: rtl/traffic_req_sequencer_if.sv
// Request/light bundle between the traffic request front end and its environment.
// slave: the sequencer's view. master: the controller/sensor side.
interface traffic_req_sequencer_if;
  logic [3:0] sns_veh;
  logic [3:0] btn_ped;
  logic [3:0] sns_emg;
  logic [2:0] east;
  logic [2:0] west;
  logic [2:0] north;
  logic [2:0] south;
  logic       P_east;
  logic       P_west;
  logic       P_north;
  logic       P_south;
  logic [3:0] traffic;
  logic [3:0] pedastrain_req;
  logic [3:0] emergency;
  logic [3:0] overdue;
  logic       emg_active;

  modport slave (
    input  sns_veh, btn_ped, sns_emg,
    input  east, west, north, south,
    input  P_east, P_west, P_north, P_south,
    output traffic, pedastrain_req, emergency, overdue, emg_active
  );

  modport master (
    output sns_veh, btn_ped, sns_emg,
    output east, west, north, south,
    output P_east, P_west, P_north, P_south,
    input  traffic, pedastrain_req, emergency, overdue, emg_active
  );
endinterface

// File: rtl/traffic_req_sequencer.sv
// Debounces vehicle/pedestrian/emergency inputs and latches served-until-cleared requests.
// Optional macro REQ_SYNC_EN inserts a 2-flop synchronizer ahead of every debouncer.
module traffic_req_sequencer #(
  parameter int DEB_CYCLES = 4,
  parameter int HOLD_MAX   = 64,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  traffic_req_sequencer_if.slave   bus
);

  localparam int              NCH      = 12;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] AGE_MAX  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    EMG_IDLE    = 2'd0,
    EMG_HOLD    = 2'd1,
    EMG_RELEASE = 2'd2
  } emg_state_e;

  // Channel map: [3:0] vehicle, [7:4] pedestrian, [11:8] emergency.
  logic [NCH-1:0] w_raw;
  logic [NCH-1:0] w_sample;

  assign w_raw = {bus.sns_emg, bus.btn_ped, bus.sns_veh};

`ifdef REQ_SYNC_EN
  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; '=' here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = w_raw;
`endif

  logic [NCH-1:0]   r_prev;
  logic [NCH-1:0]   r_lvl;
  logic [NCH-1:0]   r_lvl_d;
  logic [CNT_W-1:0] r_deb_cnt     [NCH];
  logic [CNT_W-1:0] w_deb_cnt_nxt [NCH];

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_deb_cnt_nxt[i] = r_deb_cnt[i];
      if (w_sample[i] != r_prev[i]) begin
        w_deb_cnt_nxt[i] = '0;
      end else if (r_deb_cnt[i] < DEB_LAST) begin
        w_deb_cnt_nxt[i] = r_deb_cnt[i] + CNT_ONE;
      end
    end
  end

  // The level follows the sample only once the run of equal samples is long enough.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev  <= '0;
      r_lvl   <= '0;
      r_lvl_d <= '0;
      // NOTE: these counter arrays are control state, not storage, so every element is explicitly cleared.
      for (int i = 0; i < NCH; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      r_prev  <= w_sample;
      r_lvl_d <= r_lvl;
      for (int i = 0; i < NCH; i++) begin
        r_deb_cnt[i] <= w_deb_cnt_nxt[i];
        if (w_deb_cnt_nxt[i] == DEB_LAST) begin
          r_lvl[i] <= w_sample[i];
        end
      end
    end
  end

  logic [NCH-1:0] w_rise;
  logic [3:0]     w_veh_rise;
  logic [3:0]     w_ped_rise;
  logic [3:0]     w_emg_lvl;
  logic [3:0]     w_green;
  logic [3:0]     w_walk;

  assign w_rise     = r_lvl & ~r_lvl_d;
  assign w_veh_rise = w_rise[3:0];
  assign w_ped_rise = w_rise[7:4];
  assign w_emg_lvl  = r_lvl[11:8];

  assign w_green = {bus.east  == 3'b100, bus.west  == 3'b100,
                    bus.north == 3'b100, bus.south == 3'b100};
  assign w_walk  = {bus.P_east, bus.P_west, bus.P_north, bus.P_south};

  logic [3:0] r_traffic;
  logic [3:0] r_ped;

  // A new press outranks a same-cycle service so it is never dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_traffic <= '0;
      r_ped     <= '0;
    end else begin
      r_traffic <= w_veh_rise | (r_traffic & ~w_green);
      r_ped     <= w_ped_rise | (r_ped & ~w_walk);
    end
  end

  emg_state_e r_state;
  emg_state_e w_state_nxt;
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic [3:0] w_emergency;
  logic       w_emg_active;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= EMG_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_emergency = '0;
    unique case (r_state)
      EMG_IDLE: begin
        if (|w_emg_lvl) begin
          w_state_nxt = EMG_HOLD;
          if (w_emg_lvl[3])      w_sel_nxt = 2'd3;
          else if (w_emg_lvl[2]) w_sel_nxt = 2'd2;
          else if (w_emg_lvl[1]) w_sel_nxt = 2'd1;
          else                   w_sel_nxt = 2'd0;
        end
      end
      EMG_HOLD: begin
        w_emergency = 4'b0001 << r_sel;
        if (!w_emg_lvl[r_sel]) begin
          w_state_nxt = EMG_RELEASE;
        end
      end
      EMG_RELEASE: begin
        w_state_nxt = EMG_IDLE;
      end
      default: begin
        w_state_nxt = EMG_IDLE;
      end
    endcase
  end

  assign w_emg_active = (r_state != EMG_IDLE);

  logic [CNT_W-1:0] r_age [4];
  logic [3:0]       w_pending;
  logic [3:0]       w_overdue;

  assign w_pending = r_traffic | r_ped;

  // Clearing on service takes precedence over the emergency freeze.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 4; d++) begin
        r_age[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (!w_pending[d]) begin
          r_age[d] <= '0;
        end else if (!w_emg_active && (r_age[d] < AGE_MAX)) begin
          r_age[d] <= r_age[d] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    w_overdue = '0;
    for (int d = 0; d < 4; d++) begin
      w_overdue[d] = (r_age[d] == AGE_MAX);
    end
  end

  assign bus.traffic        = r_traffic;
  assign bus.pedastrain_req = r_ped;
  assign bus.emergency      = w_emergency;
  assign bus.overdue        = w_overdue;
  assign bus.emg_active     = w_emg_active;

endmodule

// File: tb/tb_traffic_req_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each cycle
// against a run-length / direction-queue reference model of the request rules.
module tb_traffic_req_sequencer;

  localparam int DEB     = 4;
  localparam int HOLD    = 64;
  localparam int RUN_CAP = 1000;
`ifdef REQ_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  traffic_req_sequencer_if bus ();

  traffic_req_sequencer #(
    .DEB_CYCLES (DEB),
    .HOLD_MAX   (HOLD),
    .CNT_W      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit [11:0] m_pipe [2];
  bit        m_run_val [12];
  int        m_run_len [12];
  bit [11:0] m_lvl;
  bit [11:0] m_lvl_prev;
  bit [3:0]  m_traffic;
  bit [3:0]  m_ped;
  int        m_age [4];
  int        m_hold_dir;
  bit        m_release;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst, input bit [11:0] raw,
                              input bit [3:0] green, input bit [3:0] walk);
    bit [11:0] sample;
    bit [11:0] lvl_new;
    bit [11:0] rise;
    bit [3:0]  pend_old;
    bit [3:0]  emg;
    bit        active_old;
    if (!rst) begin
      m_pipe[0] = '0; m_pipe[1] = '0;
      for (int c = 0; c < 12; c++) begin
        m_run_val[c] = 1'b0;
        m_run_len[c] = DEB;
      end
      m_lvl = '0; m_lvl_prev = '0;
      m_traffic = '0; m_ped = '0;
      for (int d = 0; d < 4; d++) m_age[d] = 0;
      m_hold_dir = -1;
      m_release  = 1'b0;
      return;
    end
`ifdef REQ_SYNC_EN
    sample    = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = raw;
`else
    sample = raw;
`endif
    active_old = (m_hold_dir >= 0) || m_release;
    pend_old   = m_traffic | m_ped;
    emg        = m_lvl[11:8];
    rise       = m_lvl & ~m_lvl_prev;
    for (int c = 0; c < 12; c++) begin
      if (sample[c] == m_run_val[c]) begin
        if (m_run_len[c] < RUN_CAP) m_run_len[c]++;
      end else begin
        m_run_val[c] = sample[c];
        m_run_len[c] = 1;
      end
      lvl_new[c] = (m_run_len[c] >= DEB) ? m_run_val[c] : m_lvl[c];
    end
    m_traffic = rise[3:0] | (m_traffic & ~green);
    m_ped     = rise[7:4] | (m_ped & ~walk);
    for (int d = 0; d < 4; d++) begin
      if (!pend_old[d])                    m_age[d] = 0;
      else if (!active_old && m_age[d] < HOLD) m_age[d]++;
    end
    if (m_release) begin
      m_release = 1'b0;
    end else if (m_hold_dir < 0) begin
      for (int d = 0; d < 4; d++) if (emg[d]) m_hold_dir = d;
    end else if (!emg[m_hold_dir]) begin
      m_hold_dir = -1;
      m_release  = 1'b1;
    end
    m_lvl_prev = m_lvl;
    m_lvl      = lvl_new;
  endtask

  task automatic step_n(input int n);
    bit [11:0] raw;
    bit [3:0]  green;
    bit [3:0]  walk;
    bit        rst;
    bit [3:0]  exp_emg;
    bit [3:0]  exp_ovd;
    for (int k = 0; k < n; k++) begin
      raw   = {bus.sns_emg, bus.btn_ped, bus.sns_veh};
      green = {bus.east == 3'b100, bus.west == 3'b100, bus.north == 3'b100, bus.south == 3'b100};
      walk  = {bus.P_east, bus.P_west, bus.P_north, bus.P_south};
      rst   = reset;
      @(posedge clk);
      model_update(rst, raw, green, walk);
      #1;
      exp_emg = (m_hold_dir >= 0) ? (4'b0001 << m_hold_dir) : 4'b0000;
      for (int d = 0; d < 4; d++) exp_ovd[d] = (m_age[d] == HOLD);
      check("traffic",    32'(bus.traffic),        32'(m_traffic));
      check("ped_req",    32'(bus.pedastrain_req), 32'(m_ped));
      check("emergency",  32'(bus.emergency),      32'(exp_emg));
      check("overdue",    32'(bus.overdue),        32'(exp_ovd));
      check("emg_active", 32'(bus.emg_active),     32'((m_hold_dir >= 0) || m_release));
    end
  endtask

  task automatic set_raw(input logic [3:0] veh, input logic [3:0] ped, input logic [3:0] emg);
    bus.sns_veh = veh;
    bus.btn_ped = ped;
    bus.sns_emg = emg;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step_n(2);
    reset = 1'b1;
  endtask

  function automatic logic [2:0] pick_light();
    int p;
    p = $urandom_range(63);
    if (p == 0)     return 3'b100;
    else if (p < 4) return 3'b010;
    else            return 3'b001;
  endfunction

  initial begin
    logic [11:0] r;
    int          idx;
    set_raw(4'hF, 4'hF, 4'hF);
    bus.east = 3'b001; bus.west = 3'b001; bus.north = 3'b001; bus.south = 3'b001;
    bus.P_east = 1'b0; bus.P_west = 1'b0; bus.P_north = 1'b0; bus.P_south = 1'b0;

    // Reset with all inputs high, then first-request latency
    reset = 1'b0;
    step_n(2);
    check("rst_traffic",   32'(bus.traffic),        32'h0);
    check("rst_ped",       32'(bus.pedastrain_req), 32'h0);
    check("rst_emergency", 32'(bus.emergency),      32'h0);
    reset = 1'b1;
    step_n(4 + SD);
    check("lat_pre_traffic", 32'(bus.traffic), 32'h0);
    step_n(1);
    check("lat_traffic",   32'(bus.traffic),        32'hF);
    check("lat_ped",       32'(bus.pedastrain_req), 32'hF);
    check("lat_emg_prio",  32'(bus.emergency),      32'h8);
    step_n(3);
    reset = 1'b0;
    step_n(1);
    check("mid_rst_traffic", 32'(bus.traffic),    32'h0);
    check("mid_rst_active",  32'(bus.emg_active), 32'h0);
    set_raw(4'h0, 4'h0, 4'h0);
    do_reset();

    // Short pedestrian pulse filtered; long press latched until walk served
    step_n(3);
    set_raw(4'h0, 4'h8, 4'h0);
    step_n(2);
    set_raw(4'h0, 4'h0, 4'h0);
    step_n(8 + SD);
    check("ped_glitch", 32'(bus.pedastrain_req), 32'h0);
    set_raw(4'h0, 4'h8, 4'h0);
    step_n(4 + SD);
    check("ped_pre", 32'(bus.pedastrain_req), 32'h0);
    step_n(1);
    check("ped_set", 32'(bus.pedastrain_req), 32'h8);
    step_n(1);
    set_raw(4'h0, 4'h0, 4'h0);
    step_n(10);
    check("ped_hold", 32'(bus.pedastrain_req), 32'h8);
    bus.P_east = 1'b1;
    step_n(1);
    check("ped_clear", 32'(bus.pedastrain_req), 32'h0);
    bus.P_east = 1'b0;

    // Emergency priority, release gap, then next direction
    set_raw(4'h0, 4'h0, 4'h3);
    step_n(5 + SD);
    check("emg_north", 32'(bus.emergency), 32'h2);
    step_n(3);
    set_raw(4'h0, 4'h0, 4'h1);
    step_n(4 + SD);
    check("emg_still", 32'(bus.emergency), 32'h2);
    step_n(1);
    check("emg_release",     32'(bus.emergency),  32'h0);
    check("emg_release_act", 32'(bus.emg_active), 32'h1);
    step_n(2);
    check("emg_south", 32'(bus.emergency), 32'h1);
    set_raw(4'h0, 4'h0, 4'h0);
    step_n(10 + SD);

    // Overdue after HOLD cycles, cleared by green
    do_reset();
    set_raw(4'h2, 4'h0, 4'h0);
    step_n(5 + SD);
    check("ovd_traffic", 32'(bus.traffic), 32'h2);
    step_n(HOLD - 1);
    check("ovd_pre", 32'(bus.overdue), 32'h0);
    step_n(1);
    check("ovd_set", 32'(bus.overdue), 32'h2);
    step_n(6);
    bus.north = 3'b100;
    step_n(1);
    check("ovd_srv_traffic", 32'(bus.traffic), 32'h0);
    step_n(1);
    check("ovd_clear", 32'(bus.overdue), 32'h0);
    bus.north = 3'b001;
    set_raw(4'h0, 4'h0, 4'h0);

    // Set and clear in the same cycle: set wins
    do_reset();
    set_raw(4'h0, 4'h1, 4'h0);
    step_n(6 + SD);
    check("sc_first", 32'(bus.pedastrain_req), 32'h1);
    set_raw(4'h0, 4'h0, 4'h0);
    step_n(6 + SD);
    set_raw(4'h0, 4'h1, 4'h0);
    step_n(4 + SD);
    bus.P_south = 1'b1;
    step_n(1);
    check("sc_set_wins", 32'(bus.pedastrain_req), 32'h1);
    bus.P_south = 1'b0;
    step_n(2);
    bus.P_south = 1'b1;
    step_n(1);
    check("sc_served", 32'(bus.pedastrain_req), 32'h0);
    bus.P_south = 1'b0;
    set_raw(4'h0, 4'h0, 4'h0);

    // Random traffic against the model
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(7) == 0) begin
        r   = {bus.sns_emg, bus.btn_ped, bus.sns_veh};
        idx = $urandom_range(11);
        r[idx] = ~r[idx];
        set_raw(r[3:0], r[7:4], r[11:8]);
      end
      bus.east  = pick_light();
      bus.west  = pick_light();
      bus.north = pick_light();
      bus.south = pick_light();
      bus.P_east  = ($urandom_range(47) == 0);
      bus.P_west  = ($urandom_range(47) == 0);
      bus.P_north = ($urandom_range(47) == 0);
      bus.P_south = ($urandom_range(47) == 0);
      reset = ($urandom_range(599) == 0) ? 1'b0 : 1'b1;
      step_n(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
